niosii_v1_pio_out: RTL and testbench



---
 rtl/niosii_v1_pio_out_pkg.sv | 19 +
 rtl/niosii_v1_pio_pulse_timer.sv | 35 +++
 rtl/niosii_v1_pio_out.sv | 114 +++++++++++
 tb/tb_niosii_v1_pio_out.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/niosii_v1_pio_out_pkg.sv
// Shared constants for the output PIO: register offsets, pulse FSM states and STATUS bit positions.
package niosii_v1_pio_out_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PLEN   = 3'd1;
  localparam logic [2:0] ADDR_OUTSET = 3'd2;
  localparam logic [2:0] ADDR_OUTCLR = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_IRQ_BIT  = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/niosii_v1_pio_pulse_timer.sv
// Pulse down-counter: loads on a valid PULSE write, runs while ACTIVE, flags the final cycle via expire.
module niosii_v1_pio_pulse_timer
  import niosii_v1_pio_out_pkg::*;
#(
  parameter int PLEN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [PLEN_W-1:0] plen,
  output logic              busy,
  output logic              expire
);

  pulse_state_e      state;
  logic [PLEN_W-1:0] cnt;

  assign busy = (state == ACTIVE);
  // A retrigger on the last cycle reloads instead of expiring.
  assign expire = busy && (cnt == PLEN_W'(1)) && !load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (load) begin
      state <= ACTIVE;
      cnt   <= plen;
    end else if (busy) begin
      cnt <= cnt - PLEN_W'(1);
      if (cnt == PLEN_W'(1)) state <= IDLE;
    end
  end

endmodule

// File: rtl/niosii_v1_pio_out.sv
// Avalon-MM output PIO with set/clear registers and a hardware-timed auto-clearing pulse.
// Define NIOSII_V1_PIO_OUT_PULSE_IRQ_EN to add the pulse-done interrupt (irq_pend, STATUS bit1).
module niosii_v1_pio_out
  import niosii_v1_pio_out_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                PLEN_W      = 16,
  parameter logic [PLEN_W-1:0] PLEN_RESET  = PLEN_W'(1000)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic              wr;
  logic [WIDTH-1:0]  wd_mask;
  logic [WIDTH-1:0]  data, data_next;
  logic [WIDTH-1:0]  pmask, pmask_next;
  logic [PLEN_W-1:0] plen;
  logic [31:0]       rd_next;
  logic              pulse_load;
  logic              busy;
  logic              expire;
  logic              irq_pend;
  logic              unused_wd;

  assign wr         = chipselect & ~write_n;
  assign wd_mask    = writedata[WIDTH-1:0];
  assign pulse_load = wr && (address == ADDR_PULSE) && (|wd_mask) && (|plen);
  assign out_port   = data;
  assign irq        = irq_pend;
  assign unused_wd  = &{1'b0, writedata};

  niosii_v1_pio_pulse_timer #(.PLEN_W(PLEN_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pulse_load),
    .plen    (plen),
    .busy    (busy),
    .expire  (expire)
  );

  // Bus write lands first, expiry then clears the pulsed bits on top of it.
  always_comb begin
    data_next = data;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_next = wd_mask;
        ADDR_OUTSET: data_next = data | wd_mask;
        ADDR_OUTCLR: data_next = data & ~wd_mask;
        default:     data_next = data;
      endcase
    end
    if (pulse_load) data_next = data_next | wd_mask;
    if (expire)     data_next = data_next & ~pmask;
  end

  always_comb begin
    pmask_next = pmask;
    if (pulse_load)  pmask_next = pmask | wd_mask;
    else if (expire) pmask_next = '0;
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next[WIDTH-1:0]  = data;
      ADDR_PLEN:   rd_next[PLEN_W-1:0] = plen;
      ADDR_PULSE:  rd_next[WIDTH-1:0]  = pmask;
      ADDR_STATUS: begin
        rd_next[STATUS_BUSY_BIT] = busy;
        rd_next[STATUS_IRQ_BIT]  = irq_pend;
      end
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= RESET_VALUE;
      pmask    <= '0;
      plen     <= PLEN_RESET;
      readdata <= '0;
    end else begin
      data     <= data_next;
      pmask    <= pmask_next;
      readdata <= rd_next;
      if (wr && (address == ADDR_PLEN)) plen <= writedata[PLEN_W-1:0];
    end
  end

`ifdef NIOSII_V1_PIO_OUT_PULSE_IRQ_EN
  // Expiry beats a same-cycle clear so a completion is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= 1'b0;
    end else if (expire) begin
      irq_pend <= 1'b1;
    end else if (wr && (address == ADDR_STATUS) && writedata[STATUS_IRQ_BIT]) begin
      irq_pend <= 1'b0;
    end
  end
`else
  assign irq_pend = 1'b0;
`endif

endmodule

// File: tb/tb_niosii_v1_pio_out.sv
// Self-checking bench for niosii_v1_pio_out: directed scenarios plus random bus traffic against a deadline-based model.
module tb_niosii_v1_pio_out;

  localparam int         WIDTH  = 8;
  localparam int         PLEN_W = 16;
  localparam logic [7:0] RV     = 8'hA5;
`ifdef NIOSII_V1_PIO_OUT_PULSE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  niosii_v1_pio_out #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .PLEN_W      (PLEN_W),
    .PLEN_RESET  (16'd1000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: pulse tracked as an absolute expiry edge number rather than a counter.
  int          edge_n;
  int          m_deadline;
  bit          m_active;
  logic [7:0]  m_data;
  logic [7:0]  m_pmask;
  logic [15:0] m_plen;
  logic        m_irq;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    edge_n     = 0;
    m_deadline = 0;
    m_active   = 1'b0;
    m_data     = RV;
    m_pmask    = '0;
    m_plen     = 16'd1000;
    m_irq      = 1'b0;
    m_rd       = '0;
  endtask

  task automatic model_step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic       wr;
    logic [7:0] m;
    bit         load, fin;
    wr = cs & ~wn;
    m  = wd[7:0];
    edge_n++;
    case (a)
      3'd0:    m_rd = {24'b0, m_data};
      3'd1:    m_rd = {16'b0, m_plen};
      3'd4:    m_rd = {24'b0, m_pmask};
      3'd5:    m_rd = {30'b0, m_irq, m_active};
      default: m_rd = '0;
    endcase
    load = wr && (a == 3'd4) && (m != 0) && (m_plen != 0);
    fin  = m_active && !load && (edge_n == m_deadline);
    if (wr) begin
      case (a)
        3'd0: m_data = m;
        3'd1: m_plen = wd[15:0];
        3'd2: m_data = m_data | m;
        3'd3: m_data = m_data & ~m;
        3'd5: if (wd[1]) m_irq = 1'b0;
        default: ;
      endcase
    end
    if (load) begin
      m_data     = m_data | m;
      m_pmask    = m_pmask | m;
      m_deadline = edge_n + int'(m_plen);
      m_active   = 1'b1;
    end
    if (fin) begin
      m_data   = m_data & ~m_pmask;
      m_pmask  = '0;
      m_active = 1'b0;
      m_irq    = IRQ_EN;
    end
  endtask

  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    model_step(cs, wn, a, wd);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cycle(1'b1, 1'b1, a, 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("out_port", {24'b0, out_port}, {24'b0, m_data});
        check("readdata", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
      end
    end
  end

  initial begin
    int hi0, hi1;
    logic [2:0]  ra;
    logic [31:0] rwd;

    #1 reset_n = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    #1;
    check("reset_out_port", {24'b0, out_port}, 32'h0000_00A5);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    rd_reg(3'd1);
    check("plen_reset_read", readdata, 32'd1000);
    rd_reg(3'd5);
    check("status_reset_read", readdata, 32'h0);

    wr_reg(3'd0, 32'hFFFF_FF0F);
    check("data_write", {24'b0, out_port}, 32'h0F);
    wr_reg(3'd2, 32'h0000_00F0);
    check("outset", {24'b0, out_port}, 32'hFF);
    wr_reg(3'd3, 32'h0000_0003);
    check("outclr", {24'b0, out_port}, 32'hFC);
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    check("data_readback", readdata, 32'hFC);

    wr_reg(3'd0, 32'h0);
    wr_reg(3'd1, 32'd5);
    wr_reg(3'd4, 32'h01);
    hi0 = out_port[0] ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      rd_reg(3'd5);
      if (out_port[0]) hi0++;
    end
    check("pulse5_len", hi0, 5);
`ifdef NIOSII_V1_PIO_OUT_PULSE_IRQ_EN
    check("irq_after_pulse", {31'b0, irq}, 32'h1);
`else
    check("irq_absent", {31'b0, irq}, 32'h0);
`endif
    wr_reg(3'd5, 32'h2);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    wr_reg(3'd1, 32'd10);
    wr_reg(3'd4, 32'h01);
    hi0 = out_port[0] ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      rd_reg(3'd5);
      if (out_port[0]) hi0++;
    end
    wr_reg(3'd4, 32'h02);
    if (out_port[0]) hi0++;
    hi1 = out_port[1] ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      rd_reg(3'd4);
      if (out_port[0]) hi0++;
      if (out_port[1]) hi1++;
    end
    check("retrig_bit0_len", hi0, 14);
    check("retrig_bit1_len", hi1, 10);

    wr_reg(3'd0, 32'h40);
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd4, 32'h01);
    check("pulse_plen0", {24'b0, out_port}, 32'h40);
    rd_reg(3'd5);
    check("busy_plen0", {31'b0, readdata[0]}, 32'h0);
    wr_reg(3'd1, 32'd5);
    wr_reg(3'd4, 32'h00);
    check("pulse_mask0", {24'b0, out_port}, 32'h40);
    rd_reg(3'd5);
    check("busy_mask0", {31'b0, readdata[0]}, 32'h0);

    wr_reg(3'd0, 32'h30);
    wr_reg(3'd4, 32'h01);
    rd_reg(3'd5);
    rd_reg(3'd5);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("midpulse_reset_out", {24'b0, out_port}, 32'hA5);
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd_reg(3'd4);
    check("pmask_after_reset", readdata, 32'h0);
    rd_reg(3'd5);
    check("status_after_reset", readdata, 32'h0);
    rd_reg(3'd1);
    check("plen_after_reset", readdata, 32'd1000);

    for (int i = 0; i < 800; i++) begin
      ra  = 3'($urandom_range(0, 7));
      rwd = $urandom;
      if (ra == 3'd1) rwd = (rwd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rwd);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
